uart_rx_fifo: RTL

//  Receive buffer that sits directly downstream of uart_rx. Each new_data pulse captures the

---
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind uart_rx: stores byte plus error flags,
// drained by valid/ready, with level, threshold irq, overflow and drop status.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_new,
  input  logic          rx_err_crc,
  input  logic          rx_err_frame,
  input  logic          drop_err,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_err_crc,
  output logic          out_err_frame,
  output logic [AW:0]   count,
  output logic          full,
  input  logic [AW:0]   thr,
  output logic          thr_irq,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          thr_irq_q, thr_irq_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          err, drop, pop, push, ovf_set;
  logic [9:0]    head;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign thr_irq   = thr_irq_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

  assign head          = mem_q[rd_ptr_q];
  assign out_data      = out_valid ? head[7:0] : 8'h00;
  assign out_err_crc   = out_valid & head[8];
  assign out_err_frame = out_valid & head[9];

  always_comb begin
    err     = rx_err_crc | rx_err_frame;
    drop    = rx_new & drop_err & err;
    pop     = out_valid & out_ready;
    // a pop in the same cycle frees the slot a full FIFO needs
    push    = rx_new & ~drop & (~full | pop);
    ovf_set = rx_new & ~drop & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    thr_irq_d = (thr != '0) && (count_d >= thr);
  end

  always_comb begin
    ovf_d  = ovf_set | (ovf_q & ~ovf_clr);
    drop_d = drop_q;
    if (drop) begin
      if (ovf_clr)             drop_d = 8'h01;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'h01;
    end else if (ovf_clr) begin
      drop_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      thr_irq_q <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      thr_irq_q <= thr_irq_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem_q[wr_ptr_q] <= {rx_err_frame, rx_err_crc, rx_data};
  end

endmodule
